// File: rtl/debug_pkg.sv
// Shared definitions for the cache debug master: FSM states, command op codes
// and default sizing.
package debug_pkg;

    localparam int BRAMWORDS_DEF = 4096;
    localparam int CW_DEF        = 13;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_DUMP = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD_ADDR,
        RD_WAIT,
        RD_OUT,
        FIN
    } state_e;

endpackage

// File: rtl/cache_debug_master.sv
// Cache debug master: moves word streams into (LOAD) or out of (DUMP) a BRAM
// through its debug port. One command at a time; done pulses on completion.
module cache_debug_master
    import debug_pkg::*;
#(
    parameter int BRAMWORDS = BRAMWORDS_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic          CPU_CLK,
    input  logic          CPU_RST_N,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [31:0]   cmd_base,
    input  logic [CW-1:0] cmd_count,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_last,
    output logic [31:0]   Debug_A2,
    output logic [31:0]   Debug_WD2,
    output logic [3:0]    Debug_WE2,
    input  logic [31:0]   Debug_RD2,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [31:0]   a2_q, a2_d;
    logic [31:0]   wd_q, wd_d;
    logic [3:0]    we_q, we_d;
    logic [31:0]   od_q, od_d;

    logic [31:0]   base_al;
    logic [CW-1:0] cnt_c;
    logic          unused_base;

    // Byte-lane bits of the base address carry no meaning for word transfers.
    assign unused_base = ^cmd_base[1:0];
    assign base_al     = {cmd_base[31:2], 2'b00};
    assign cnt_c       = (cmd_count > CW'(BRAMWORDS)) ? CW'(BRAMWORDS) : cmd_count;

    // Handshake and status outputs decode straight from the state register;
    // cmd_ready is also gated by reset so it stays low while reset is held.
    assign cmd_ready = (state_q == IDLE) && CPU_RST_N;
    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == RD_OUT);
    assign out_last  = (state_q == RD_OUT) && (rem_q == CW'(1));
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign out_data  = od_q;
    assign Debug_A2  = a2_q;
    assign Debug_WD2 = wd_q;
    assign Debug_WE2 = we_q;

    // Next-state logic. The read address is preloaded into the A2 register on
    // the way into RD_ADDR so the BRAM samples it at the end of RD_ADDR.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        a2_d    = a2_q;
        wd_d    = wd_q;
        we_d    = 4'b0000;
        od_d    = od_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = base_al;
                    rem_d  = cnt_c;
                    if (cnt_c == '0) begin
                        state_d = FIN;
                    end else if (cmd_op == OP_LOAD) begin
                        state_d = LOAD;
                    end else begin
                        state_d = RD_ADDR;
                        a2_d    = base_al;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    a2_d   = addr_q;
                    wd_d   = in_data;
                    we_d   = 4'b1111;
                    addr_d = addr_q + 32'd4;
                    rem_d  = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
                od_d    = Debug_RD2;
                state_d = RD_OUT;
            end
            RD_OUT: begin
                if (out_ready) begin
                    addr_d = addr_q + 32'd4;
                    rem_d  = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = FIN;
                    end else begin
                        state_d = RD_ADDR;
                        a2_d    = addr_q + 32'd4;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything so a partial
    // transfer is abandoned with no write left pending.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            a2_q    <= '0;
            wd_q    <= '0;
            we_q    <= '0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            a2_q    <= a2_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            od_q    <= od_d;
        end
    end

endmodule
